cache_memory: RTL and testbench
===============================

Name: cache_memory

Overview:
- Responder side of the controller-to-memory interface of the cache.
- Holds NUM_ENTRIES key/value slots with a per-slot used bit.
- Executes one command per cycle: associative key lookup, indexed write, or indexed delete.
- Returns registered hit/index/value responses and occupancy status to the controller and its sub-FSMs.

Parameters:
- NUM_ENTRIES, 16, number of slots; one-hot index width.
- KEY_WIDTH, 32, key width in bits.
- VALUE_WIDTH, 64, value width in bits.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- select_in  input  1  lookup request for key_in.
- write_in  input  1  write key_in/value_in into slot idx_in.
- delete_in  input  1  invalidate slot idx_in.
- idx_in  input  NUM_ENTRIES  one-hot target slot for write/delete.
- key_in  input  KEY_WIDTH  lookup/write key.
- value_in  input  VALUE_WIDTH  write data.
- valid_out  output  1  one-cycle pulse: response for the previous-cycle command.
- hit_out  output  1  lookup found key (qualified by valid_out).
- hit_idx_out  output  NUM_ENTRIES  one-hot slot of hit; 0 on miss.
- value_out  output  VALUE_WIDTH  value of hit slot; 0 on miss.
- error_out  output  1  previous command rejected (qualified by valid_out).
- used_out  output  NUM_ENTRIES  registered used bits.
- free_idx_out  output  NUM_ENTRIES  combinational one-hot of the lowest-index unused slot; 0 when full.
- full_out  output  1  all slots used (combinational from used).
- count_out  output  $clog2(NUM_ENTRIES)+1  registered number of used slots.

Behaviour:
- Reset (async assert, sync release):
  - used, keys, values, count cleared to 0.
  - valid_out, hit_out, hit_idx_out, value_out, error_out all 0.
  - A command in flight at reset is discarded; no response pulse after release.
- Command decode per cycle:
  - Idle (no strobe): no state change; valid_out=0 next cycle.
  - More than one of select/write/delete high: reject, error_out=1, no state change.
- Latency: every accepted or rejected command produces valid_out=1 exactly one cycle later, for exactly one cycle. Back-to-back commands give back-to-back pulses.
- Lookup (select_in only):
  - Compare key_in against all slots with used=1.
  - Match in exactly one slot: hit_out=1, that slot's one-hot on hit_idx_out, its value on value_out.
  - No match: hit_out=0, hit_idx_out=0, value_out=0, error_out=0.
  - Duplicate keys (multiple matches): report the lowest-index match and set error_out=1.
  - Unused slots never match, even when their stale key equals key_in.
- Write (write_in only):
  - idx_in must be exactly one-hot, else error_out=1 and no change.
  - Target slot stores key_in/value_in and sets used.
  - count increments only if the slot was previously unused; overwriting a used slot leaves count unchanged.
  - Response: hit_out=0, error_out=0.
  - No key-uniqueness check; the controller guarantees uniqueness.
- Delete (delete_in only):
  - idx_in must be one-hot, else error.
  - Delete of an unused slot: error_out=1, no change.
  - Otherwise clear used and decrement count; key/value contents are kept (don't-care).
  - Response: hit_out=1 and hit_idx_out=idx_in on success.
- Read-after-write: state updates on the command edge, so a lookup in the cycle after a write/delete sees the new state.
- Status signals:
  - used_out and count_out update on the same edge as the state change.
  - free_idx_out and full_out follow used_out combinationally.
- Invariant: count_out always equals popcount(used_out); never overflows or underflows.
- Outputs not relevant to a response (e.g. value_out on write/delete) are driven 0.

Test Plan:
- Reset, then write key 0xA5 value 0x1234 to idx 0x0001 -> next cycle valid_out=1, error_out=0, used_out=0x0001, count_out=1, free_idx_out=0x0002.
- Lookup key 0xA5 one cycle later -> valid_out=1, hit_out=1, hit_idx_out=0x0001, value_out=0x1234. Lookup key 0x77 -> hit_out=0, hit_idx_out=0, value_out=0.
- Write all 16 slots keys 0..15 -> full_out=1, free_idx_out=0, count_out=16. Overwrite slot 0x0008 -> count_out stays 16.
- Delete idx 0x0004 -> hit_out=1, used_out bit2=0, count_out=15, free_idx_out=0x0004. Lookup key 2 -> miss. Delete 0x0004 again -> error_out=1, count unchanged.
- Illegal commands: write with idx 0x0003, then select+delete together -> each gives valid_out=1, error_out=1, used_out unchanged.
- Assert rst_n=0 mid-sequence with write strobe high -> used_out=0, count_out=0, outputs 0 immediately. After release, no valid_out pulse until a new command.

Source files
------------

// File: rtl/cache_memory.sv
// cache_memory: key/value slot store answering the cache controller.
// Ports: clk/rst_n; select_in/write_in/delete_in commands with idx_in,
//   key_in, value_in; registered valid/hit/hit_idx/value/error responses;
//   used_out/count_out registered, free_idx_out/full_out combinational.
module cache_memory #(
   parameter int NUM_ENTRIES = 16,
   parameter int KEY_WIDTH   = 32,
   parameter int VALUE_WIDTH = 64,
   localparam int CW = $clog2(NUM_ENTRIES) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   select_in,
   input  logic                   write_in,
   input  logic                   delete_in,
   input  logic [NUM_ENTRIES-1:0] idx_in,
   input  logic [KEY_WIDTH-1:0]   key_in,
   input  logic [VALUE_WIDTH-1:0] value_in,
   output logic                   valid_out,
   output logic                   hit_out,
   output logic [NUM_ENTRIES-1:0] hit_idx_out,
   output logic [VALUE_WIDTH-1:0] value_out,
   output logic                   error_out,
   output logic [NUM_ENTRIES-1:0] used_out,
   output logic [NUM_ENTRIES-1:0] free_idx_out,
   output logic                   full_out,
   output logic [CW-1:0]          count_out
);

   logic [KEY_WIDTH-1:0]   r_key [NUM_ENTRIES];
   logic [VALUE_WIDTH-1:0] r_val [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] r_used;
   logic [CW-1:0]          r_count;
   logic                   r_valid;
   logic                   r_hit;
   logic [NUM_ENTRIES-1:0] r_hidx;
   logic [VALUE_WIDTH-1:0] r_value;
   logic                   r_err;

   logic [NUM_ENTRIES-1:0] w_match;
   logic [NUM_ENTRIES-1:0] w_first;
   logic [VALUE_WIDTH-1:0] w_hit_val;
   logic                   w_dup;
   logic                   w_onehot;
   logic                   w_multi;
   logic                   w_any;
   logic                   w_slot_used;

   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++)
         w_match[i] = r_used[i] && (r_key[i] == key_in);
   end

   // Isolate lowest set bit; any second bit means duplicate keys.
   assign w_first = w_match & (~w_match + NUM_ENTRIES'(1));
   assign w_dup   = |(w_match & (w_match - NUM_ENTRIES'(1)));

   // w_first has at most one bit set, so an OR-mux is sufficient.
   always_comb begin
      w_hit_val = '0;
      for (int i = 0; i < NUM_ENTRIES; i++)
         if (w_first[i]) w_hit_val = w_hit_val | r_val[i];
   end

   assign w_onehot = (idx_in != '0) &&
                     ((idx_in & (idx_in - NUM_ENTRIES'(1))) == '0);
   assign w_multi  = (select_in & write_in) | (select_in & delete_in) |
                     (write_in & delete_in);
   assign w_any    = select_in | write_in | delete_in;
   assign w_slot_used = |(r_used & idx_in);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            r_key[i] <= '0;
            r_val[i] <= '0;
         end
         r_used  <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
         r_hit   <= 1'b0;
         r_hidx  <= '0;
         r_value <= '0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= w_any;
         r_hit   <= 1'b0;
         r_hidx  <= '0;
         r_value <= '0;
         r_err   <= 1'b0;
         if (w_multi) begin
            r_err <= 1'b1;
         end else if (select_in) begin
            r_hit   <= |w_match;
            r_hidx  <= w_first;
            r_value <= w_hit_val;
            r_err   <= w_dup;
         end else if (write_in) begin
            if (!w_onehot) begin
               r_err <= 1'b1;
            end else begin
               for (int i = 0; i < NUM_ENTRIES; i++) begin
                  if (idx_in[i]) begin
                     r_key[i] <= key_in;
                     r_val[i] <= value_in;
                  end
               end
               r_used <= r_used | idx_in;
               if (!w_slot_used) r_count <= r_count + CW'(1);
            end
         end else if (delete_in) begin
            if (!w_onehot || !w_slot_used) begin
               r_err <= 1'b1;
            end else begin
               r_used  <= r_used & ~idx_in;
               r_count <= r_count - CW'(1);
               r_hit   <= 1'b1;
               r_hidx  <= idx_in;
            end
         end
      end
   end

   assign valid_out    = r_valid;
   assign hit_out      = r_hit;
   assign hit_idx_out  = r_hidx;
   assign value_out    = r_value;
   assign error_out    = r_err;
   assign used_out     = r_used;
   assign count_out    = r_count;
   // Lowest zero bit of used; wraps to zero when every slot is used.
   assign free_idx_out = ~r_used & (r_used + NUM_ENTRIES'(1));
   assign full_out     = &r_used;

endmodule

// File: tb/tb_cache_memory.sv
// tb_cache_memory: table vectors, reset corner case and random
// commands checked against a slot-array reference model.
module tb_cache_memory;

   localparam int N  = 16;
   localparam int KW = 32;
   localparam int VW = 64;
   localparam int CW = 5;

   logic          clk;
   logic          rst_n;
   logic          sel, wr, del;
   logic [N-1:0]  idx;
   logic [KW-1:0] key;
   logic [VW-1:0] val;
   logic          valid_o, hit_o, err_o, full_o;
   logic [N-1:0]  hidx_o, used_o, free_o;
   logic [VW-1:0] value_o;
   logic [CW-1:0] count_o;

   cache_memory #(
      .NUM_ENTRIES(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .select_in(sel), .write_in(wr), .delete_in(del),
      .idx_in(idx), .key_in(key), .value_in(val),
      .valid_out(valid_o), .hit_out(hit_o), .hit_idx_out(hidx_o),
      .value_out(value_o), .error_out(err_o), .used_out(used_o),
      .free_idx_out(free_o), .full_out(full_o), .count_out(count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          v;
      logic          h;
      logic [N-1:0]  hidx;
      logic [VW-1:0] val;
      logic          e;
   } rsp_t;

   typedef struct {
      logic          s, w, d;
      logic [N-1:0]  idx;
      logic [KW-1:0] k;
      logic [VW-1:0] v;
      rsp_t          exp;
      logic [N-1:0]  eused;
      int            ecount;
   } vec_t;

   // Reference model: plain slot arrays.
   logic [KW-1:0] m_key [N];
   logic [VW-1:0] m_val [N];
   bit            m_used [N];

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_key[i] = '0;
         m_val[i] = '0;
         m_used[i] = 0;
      end
   endfunction

   function automatic logic [N-1:0] model_used();
      logic [N-1:0] u = '0;
      for (int i = 0; i < N; i++) u[i] = m_used[i];
      return u;
   endfunction

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < N; i++) if (m_used[i]) c++;
      return c;
   endfunction

   function automatic logic [N-1:0] lowest_free(input logic [N-1:0] u);
      logic [N-1:0] one = 1;
      for (int i = 0; i < N; i++) if (!u[i]) return one << i;
      return '0;
   endfunction

   function automatic rsp_t model_cmd(input logic s, w, d,
                                      input logic [N-1:0] ix,
                                      input logic [KW-1:0] k,
                                      input logic [VW-1:0] v);
      rsp_t r;
      int ns, slot, first, nm;
      logic [N-1:0] one = 1;
      r = '{v: 0, h: 0, hidx: '0, val: '0, e: 0};
      ns = int'(s) + int'(w) + int'(d);
      slot = -1;
      for (int i = 0; i < N; i++) if (ix[i] && slot < 0) slot = i;
      if (ns == 0) return r;
      r.v = 1;
      if (ns > 1) begin
         r.e = 1;
      end else if (s) begin
         first = -1;
         nm = 0;
         for (int i = 0; i < N; i++) begin
            if (m_used[i] && m_key[i] == k) begin
               nm++;
               if (first < 0) first = i;
            end
         end
         if (nm > 0) begin
            r.h = 1;
            r.hidx = one << first;
            r.val = m_val[first];
         end
         r.e = (nm > 1);
      end else if (w) begin
         if ($countones(ix) != 1) r.e = 1;
         else begin
            m_key[slot] = k;
            m_val[slot] = v;
            m_used[slot] = 1;
         end
      end else begin
         if ($countones(ix) != 1 || !m_used[slot]) r.e = 1;
         else begin
            m_used[slot] = 0;
            r.h = 1;
            r.hidx = ix;
         end
      end
      return r;
   endfunction

   task automatic check_rsp(input string t, input rsp_t ex,
                            input logic [N-1:0] eu, input int ec);
      chk({t, ".valid"}, 64'(valid_o), 64'(ex.v));
      chk({t, ".hit"}, 64'(hit_o), 64'(ex.h));
      chk({t, ".hit_idx"}, 64'(hidx_o), 64'(ex.hidx));
      chk({t, ".value"}, value_o, ex.val);
      chk({t, ".error"}, 64'(err_o), 64'(ex.e));
      chk({t, ".used"}, 64'(used_o), 64'(eu));
      chk({t, ".count"}, 64'(count_o), 64'(ec));
      chk({t, ".free"}, 64'(free_o), 64'(lowest_free(eu)));
      chk({t, ".full"}, 64'(full_o), 64'(eu == '1));
   endtask

   function automatic vec_t mk(input logic s, w, d,
                               input logic [N-1:0] ix,
                               input logic [KW-1:0] k,
                               input logic [VW-1:0] v,
                               input logic ev, eh,
                               input logic [N-1:0] ehidx,
                               input logic [VW-1:0] evalue,
                               input logic ee,
                               input logic [N-1:0] eu,
                               input int ec);
      vec_t t;
      t.s = s; t.w = w; t.d = d;
      t.idx = ix; t.k = k; t.v = v;
      t.exp = '{v: ev, h: eh, hidx: ehidx, val: evalue, e: ee};
      t.eused = eu;
      t.ecount = ec;
      return t;
   endfunction

   task automatic drive(input logic s, w, d, input logic [N-1:0] ix,
                        input logic [KW-1:0] k, input logic [VW-1:0] v);
      sel = s; wr = w; del = d;
      idx = ix; key = k; val = v;
   endtask

   vec_t tbl[$];
   rsp_t zr;

   initial begin
      logic [N-1:0] one;
      logic [N:0] u17;
      rsp_t r;
      int kind;
      one = 1;
      zr = '{v: 0, h: 0, hidx: '0, val: '0, e: 0};

      tbl.push_back(mk(0,1,0,16'h0001,'hA5,'h1234,
                       1,0,0,0,0,16'h0001,1));
      tbl.push_back(mk(1,0,0,0,'hA5,0,
                       1,1,16'h0001,'h1234,0,16'h0001,1));
      tbl.push_back(mk(1,0,0,0,'h77,0, 1,0,0,0,0,16'h0001,1));
      tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,16'h0001,1));
      for (int i = 0; i < N; i++) begin
         u17 = (17'd1 << (i + 1)) - 17'd1;
         tbl.push_back(mk(0,1,0,one << i,KW'(i),64'h100 + 64'(i),
                          1,0,0,0,0,u17[N-1:0],i + 1));
      end
      tbl.push_back(mk(0,1,0,16'h0008,3,'h999, 1,0,0,0,0,16'hFFFF,16));
      tbl.push_back(mk(1,0,0,0,3,0, 1,1,16'h0008,'h999,0,16'hFFFF,16));
      tbl.push_back(mk(0,0,1,16'h0004,0,0,
                       1,1,16'h0004,0,0,16'hFFFB,15));
      tbl.push_back(mk(1,0,0,0,2,0, 1,0,0,0,0,16'hFFFB,15));
      tbl.push_back(mk(0,0,1,16'h0004,0,0, 1,0,0,0,1,16'hFFFB,15));
      tbl.push_back(mk(0,1,0,16'h0003,9,'h9, 1,0,0,0,1,16'hFFFB,15));
      tbl.push_back(mk(1,0,1,16'h0001,0,0, 1,0,0,0,1,16'hFFFB,15));
      tbl.push_back(mk(0,0,1,16'h0000,0,0, 1,0,0,0,1,16'hFFFB,15));
      tbl.push_back(mk(0,1,0,16'h0004,5,'h55, 1,0,0,0,0,16'hFFFF,16));
      tbl.push_back(mk(1,0,0,0,5,0, 1,1,16'h0004,'h55,1,16'hFFFF,16));
      tbl.push_back(mk(1,0,0,0,15,0,
                       1,1,16'h8000,'h10F,0,16'hFFFF,16));

      rst_n = 1'b0;
      drive(0,0,0,'0,'0,'0);
      model_reset();
      repeat (2) @(negedge clk);
      check_rsp("reset", zr, '0, 0);
      rst_n = 1'b1;

      foreach (tbl[n]) begin
         drive(tbl[n].s, tbl[n].w, tbl[n].d,
               tbl[n].idx, tbl[n].k, tbl[n].v);
         r = model_cmd(tbl[n].s, tbl[n].w, tbl[n].d,
                       tbl[n].idx, tbl[n].k, tbl[n].v);
         @(negedge clk);
         check_rsp($sformatf("vec%0d", n), tbl[n].exp,
                   tbl[n].eused, tbl[n].ecount);
      end

      // Reset asserted mid-cycle while a write is being presented.
      drive(0,1,0,16'h0010,'h77,'h77);
      #2 rst_n = 1'b0;
      #1;
      check_rsp("async_rst", zr, '0, 0);
      model_reset();
      @(negedge clk);
      drive(0,0,0,'0,'0,'0);
      rst_n = 1'b1;
      @(negedge clk);
      check_rsp("post_rst0", zr, '0, 0);
      @(negedge clk);
      check_rsp("post_rst1", zr, '0, 0);

      for (int n = 0; n < 400; n++) begin
         logic s, w, d;
         logic [N-1:0] ix;
         kind = $urandom_range(0, 9);
         s = (kind >= 1 && kind <= 3);
         w = (kind >= 4 && kind <= 6);
         d = (kind >= 7 && kind <= 8);
         if (kind == 9) begin
            s = 1'($urandom);
            w = 1'($urandom);
            d = ~(s & w) | 1'($urandom);
            if (!s && !w) s = 1'b1;
         end
         if ($urandom_range(0, 9) < 8) ix = one << $urandom_range(0, N-1);
         else ix = N'($urandom);
         drive(s, w, d, ix, KW'($urandom_range(0, 11)),
               {32'($urandom), 32'($urandom)});
         r = model_cmd(s, w, d, ix, key, val);
         @(negedge clk);
         check_rsp($sformatf("rnd%0d", n), r, model_used(),
                   model_count());
      end

      drive(0,0,0,'0,'0,'0);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
